sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, byte-wide first-in/first-out buffer with occupancy count and full/empty flags. It decouples a byte producer from a byte consumer running on the same clock, e.g. between a parallel data source and a serializer. Writes and reads are independent, level-sensitive enables sampled on the rising clock edge. Output data is registered.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 7, number of storage entries; must be ≤ 2**CNT_WIDTH − 1.
- CNT_WIDTH, 3, width of `counter` and of the read/write pointers.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- buf_in  in  DATA_WIDTH  write data, sampled when a write is accepted.
- wr_en  in  1  write request, level-sensitive, one word per cycle.
- rd_en  in  1  read request, level-sensitive, one word per cycle.
- buf_out  out  DATA_WIDTH  registered read data.
- empty  out  1  high when counter == 0.
- full  out  1  high when counter == DEPTH.
- counter  out  CNT_WIDTH  number of words currently stored (0..DEPTH).

## Operation
- State:
  - storage array mem[0..DEPTH-1];
  - write pointer wr_ptr and read pointer rd_ptr, each CNT_WIDTH bits;
  - counter;
  - buf_out register.
- Reset (rst high, asynchronous, overrides everything):
  - wr_ptr = rd_ptr = counter = 0; buf_out = 0.
  - Hence empty = 1, full = 0.
  - mem contents are not reset.
- Write accepted: wr_en high and (not full, or a read is accepted in the same cycle).
  - mem[wr_ptr] ← buf_in.
  - wr_ptr advances by 1, wrapping from DEPTH−1 to 0.
- Read accepted: rd_en high and not empty.
  - buf_out ← mem[rd_ptr].
  - rd_ptr advances, wrapping from DEPTH−1 to 0.
- Counter update:
  - +1 on write only; −1 on read only; unchanged on both or neither.
- Rejected requests:
  - Write while full with no accepted read: dropped; no state change.
  - Read while empty: ignored; buf_out holds its previous value.
- Simultaneous wr_en and rd_en:
  - Empty: only the write is accepted; counter becomes 1; buf_out unchanged.
  - Full: both accepted; counter stays DEPTH; full stays high.
  - Otherwise: both accepted; counter unchanged.
- empty and full are decoded combinationally from counter only; never both high.
- buf_out holds its value whenever no read is accepted.

## Timing
- Write-to-visible latency:
  - A word written at edge N can be read by a read request sampled at edge N+1.
  - That word appears on buf_out after edge N+1.
- Read latency: 1 cycle. buf_out updates on the same edge that accepts the read.
- counter, empty and full reflect each edge's operation immediately after that edge.
- Throughput: one write and one read per cycle, sustained.
- Reset mid-operation: all stored data is discarded immediately, without waiting for a clock edge. The first cycle after rst deasserts behaves as an empty FIFO.

## Structure
- No shared package needed. DATA_WIDTH, DEPTH and CNT_WIDTH are module parameters.
- One sub-module is natural: `fifo_mem`, a DEPTH×DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Synchronous registered read port (re, raddr, rdata) with asynchronous reset of rdata.
- Pointer/counter control and flag decode stay in the top level.
- Add an elaboration-time check that DEPTH ≤ 2**CNT_WIDTH − 1.

## Test plan
- Reset:
  - Assert rst mid-stream with 3 words stored.
  - Required: counter = 0, empty = 1, full = 0, buf_out = 0 immediately, without waiting for an edge.
- Fill to full:
  - After reset, hold wr_en for 8 cycles with buf_in = 0,1,2,3,4,5,6,7.
  - Required: counter steps 1..7, full = 1 after the 7th edge.
  - Value 7 is dropped; counter stays 7.
- Drain in order:
  - From the full state, hold rd_en for 8 cycles.
  - Required: buf_out = 0,1,2,3,4,5,6 on successive edges; counter steps down to 0; empty = 1.
  - 8th read is ignored; buf_out holds 6.
- Wrap-around:
  - Write 5, read 5, then write 0xA0..0xA5 and read them back.
  - Required: values return in order across the pointer wrap.
  - counter matches the number of words stored throughout.
- Simultaneous read and write:
  - Case 1: empty, wr_en = rd_en = 1 with buf_in = 0x55. Required: counter = 1, buf_out unchanged.
  - Case 2: full, write 0x99 while reading. Required: oldest word on buf_out, counter stays 7, and 0x99 is read out last.
- Read when empty:
  - rd_en = 1 for 3 cycles after a drain.
  - Required: buf_out, counter and pointers unchanged; empty stays 1.

Source files
------------

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array for the byte FIFO.
// Synchronous write port and a registered read port whose output resets asynchronously.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 7,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with occupancy counter and full/empty flags.
// Pointer/counter control lives here; storage is in fifo_mem.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 7,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  counter
);

  if (DEPTH > (2**CNT_WIDTH) - 1) begin : g_depth_check
    $error("sync_fifo: DEPTH must not exceed 2**CNT_WIDTH - 1");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic                 wr_acc;
  logic                 rd_acc;

  assign empty = (counter_q == '0);
  assign full  = (counter_q == FULL_CNT);

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    counter_d = counter_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + CNT_WIDTH'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + CNT_WIDTH'(1);
    if (wr_acc && !rd_acc)      counter_d = counter_q + CNT_WIDTH'(1);
    else if (rd_acc && !wr_acc) counter_d = counter_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      counter_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (CNT_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (buf_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (buf_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: queue-based reference model compared every cycle,
// plus literal expectations along fill, drain, wrap, simultaneous and reset scenarios.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 7;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] buf_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] buf_out;
  logic          empty;
  logic          full;
  logic [CW-1:0] counter;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .buf_in  (buf_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .buf_out (buf_out),
    .empty   (empty),
    .full    (full),
    .counter (counter)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored words and the last word read out.
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_out = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_out = '0;
    end else begin
      bit rd_ok, wr_ok;
      rd_ok = rd_en && (q.size() > 0);
      wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_out = q.pop_front();
      if (wr_ok) q.push_back(buf_in);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_counter", int'(counter), q.size());
      check("model_empty", int'(empty), int'(q.size() == 0));
      check("model_full", int'(full), int'(q.size() == DEPTH));
      check("model_buf_out", int'(buf_out), int'(exp_out));
    end
  end

  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en  = w;
    rd_en  = r;
    buf_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_counter", int'(counter), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_buf_out", int'(buf_out), 0);

    // Mid-stream asynchronous reset with 3 words stored.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h11 * (i + 1));
    cycle(1'b0, 1'b1, 8'h00);
    check("pre_rst_counter", int'(counter), 3);
    check("pre_rst_buf_out", int'(buf_out), 8'h11);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_counter", int'(counter), 0);
    check("async_rst_empty", int'(empty), 1);
    check("async_rst_full", int'(full), 0);
    check("async_rst_buf_out", int'(buf_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill: the 8th write (value 7) is dropped.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      check("fill_counter", int'(counter), (i + 1 > 7) ? 7 : i + 1);
      check("fill_full", int'(full), (i >= 6) ? 1 : 0);
    end

    // Drain: values 0..6 in order, 8th read ignored.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("drain_buf_out", int'(buf_out), (i > 6) ? 6 : i);
      check("drain_counter", int'(counter), (i >= 6) ? 0 : 6 - i);
    end
    check("drain_empty", int'(empty), 1);

    // Reads on an empty FIFO are ignored.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'hEE);
      check("rd_empty_buf_out", int'(buf_out), 6);
      check("rd_empty_counter", int'(counter), 0);
      check("rd_empty_flag", int'(empty), 1);
    end

    // Wrap-around: advance pointers by 5, then cross the wrap point.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i));
    check("wrap_pre_counter", int'(counter), 5);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("wrap_pre_buf_out", int'(buf_out), 8'h10 + i);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, DW'(8'hA0 + i));
      check("wrap_wr_counter", int'(counter), i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("wrap_rd_buf_out", int'(buf_out), 8'hA0 + i);
      check("wrap_rd_counter", int'(counter), 5 - i);
    end

    // Simultaneous on empty: only the write lands.
    cycle(1'b1, 1'b1, 8'h55);
    check("sim_empty_counter", int'(counter), 1);
    check("sim_empty_buf_out", int'(buf_out), 8'hA5);

    // Fill up behind 0x55, then write+read while full.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'(8'h60 + i));
    check("sim_full_pre", int'(full), 1);
    cycle(1'b1, 1'b1, 8'h99);
    check("sim_full_buf_out", int'(buf_out), 8'h55);
    check("sim_full_counter", int'(counter), 7);
    check("sim_full_flag", int'(full), 1);

    // Partially full simultaneous: counter unchanged.
    cycle(1'b0, 1'b1, 8'h00);
    check("sim_mid_pre", int'(buf_out), 8'h60);
    cycle(1'b1, 1'b1, 8'h77);
    check("sim_mid_buf_out", int'(buf_out), 8'h61);
    check("sim_mid_counter", int'(counter), 6);

    // Drain remainder: 0x62..0x65, 0x99, 0x77.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      v = (i < 4) ? DW'(8'h62 + i) : ((i == 4) ? 8'h99 : 8'h77);
      check("final_drain", int'(buf_out), int'(v));
    end
    check("final_empty", int'(empty), 1);

    cycle(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
